// File: rtl/dma_slot_arbiter_if.sv
// Chip-bus slot arbiter bus bundle: beam position, DMA/CPU requests in,
// slot grant, channel indices and stats readback out.
interface dma_slot_arbiter_if;
  logic        slot_stb;
  logic [7:0]  HCTR;
  logic        dsk_req;
  logic [3:0]  aud_req;
  logic [7:0]  spr_req;
  logic        bpl_en;
  logic [2:0]  bpl_num;
  logic [7:0]  ddfstrt;
  logic [7:0]  ddfstop;
  logic        cop_req;
  logic        blt_req;
  logic        blt_nasty;
  logic        cpu_req;
  logic        vsync_stb;
  logic [2:0]  stat_sel;
  logic [7:0]  gnt;
  logic [2:0]  bpl_plane;
  logic [2:0]  spr_num;
  logic [1:0]  aud_ch;
  logic        cpu_ack;
  logic        PAD_NDBR;
  logic [15:0] stat_cnt;

  // Arbiter side
  modport slave (
    input  slot_stb, HCTR, dsk_req, aud_req, spr_req, bpl_en, bpl_num,
           ddfstrt, ddfstop, cop_req, blt_req, blt_nasty, cpu_req,
           vsync_stb, stat_sel,
    output gnt, bpl_plane, spr_num, aud_ch, cpu_ack, PAD_NDBR, stat_cnt
  );

  // Beam counter / requester side
  modport master (
    output slot_stb, HCTR, dsk_req, aud_req, spr_req, bpl_en, bpl_num,
           ddfstrt, ddfstop, cop_req, blt_req, blt_nasty, cpu_req,
           vsync_stb, stat_sel,
    input  gnt, bpl_plane, spr_num, aud_ch, cpu_ack, PAD_NDBR, stat_cnt
  );
endinterface

// File: rtl/dma_slot_arbiter.sv
// dma_slot_arbiter: picks one chip-bus owner per colour-clock slot
// (refresh, disk, audio, bitplane, sprite, copper, blitter, CPU).
// Optional build macro ARB_STATS_EN adds per-owner granted-slot counters
// readable through stat_cnt; without it stat_cnt is tied to zero.
module dma_slot_arbiter #(
  parameter logic [7:0]  REF_FIRST  = 8'h03,
  parameter logic [7:0]  DSK_FIRST  = 8'h0B,
  parameter logic [7:0]  AUD_FIRST  = 8'h11,
  parameter logic [7:0]  SPR_FIRST  = 8'h19,
  parameter int unsigned CPU_STARVE = 3
) (
  input  logic               PAD_C28M,
  input  logic               PAD_NRST,
  dma_slot_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    BPL_IDLE  = 2'd0,
    BPL_FETCH = 2'd1,
    BPL_LAST  = 2'd2
  } bpl_state_e;

  localparam logic [2:0] STARVE_LIM = 3'(CPU_STARVE);

  bpl_state_e bpl_state_q, bpl_state_d;

  logic [7:0] gnt_q, gnt_d;
  logic [2:0] plane_q, plane_d;
  logic [2:0] spr_q, spr_d;
  logic [1:0] aud_q, aud_d;
  logic [2:0] starve_q, starve_d;
  logic       cpu_ack_q;
  logic       ndbr_q;

  logic [7:0] hctr;
  logic [7:0] ref_off, dsk_off, aud_off, spr_off, grp_off;
  logic [2:0] grp_k;
  logic [2:0] k_plane;
  logic [1:0] aud_idx;
  logic [2:0] spr_idx;
  logic       ref_hit, dsk_hit, aud_hit, spr_hit, cop_hit, bpl_hit;
  logic       bpl_abort, bpl_active;

  assign hctr = bus.HCTR;

  // Offsets from each channel's first slot; slots below the first wrap to
  // large values so a single upper-bound compare selects the window.
  assign ref_off = hctr - REF_FIRST;
  assign dsk_off = hctr - DSK_FIRST;
  assign aud_off = hctr - AUD_FIRST;
  assign spr_off = hctr - SPR_FIRST;
  assign grp_off = hctr - bus.ddfstrt;
  assign grp_k   = grp_off[2:0];

  assign aud_idx = aud_off[2:1];
  assign spr_idx = spr_off[4:2];

  assign ref_hit = (ref_off <= 8'd6) && !ref_off[0];
  assign dsk_hit = (dsk_off <= 8'd4) && !dsk_off[0] && bus.dsk_req;
  assign aud_hit = (aud_off <= 8'd6) && !aud_off[0] && bus.aud_req[aud_idx];
  assign spr_hit = (spr_off <= 8'd30) && !spr_off[0] && bus.spr_req[spr_idx];
  assign cop_hit = !hctr[0] && bus.cop_req;

  // Plane fetched at each position of an 8-slot fetch group (0 = no fetch)
  always_comb begin
    k_plane = 3'd0;
    case (grp_k)
      3'd1:    k_plane = 3'd4;
      3'd2:    k_plane = 3'd6;
      3'd3:    k_plane = 3'd2;
      3'd5:    k_plane = 3'd3;
      3'd6:    k_plane = 3'd5;
      3'd7:    k_plane = 3'd1;
      default: k_plane = 3'd0;
    endcase
  end

  assign bpl_abort = (hctr == 8'd0) || !bus.bpl_en;

  // Bitplane fetch window: next state and whether this slot is inside it.
  // The start slot itself opens the first group, so a stop at or before the
  // start goes straight to the last group.
  always_comb begin
    bpl_state_d = bpl_state_q;
    bpl_active  = 1'b0;
    if (bpl_abort) begin
      bpl_state_d = BPL_IDLE;
    end else begin
      case (bpl_state_q)
        BPL_IDLE: begin
          if (hctr == bus.ddfstrt) begin
            bpl_active  = 1'b1;
            bpl_state_d = (hctr >= bus.ddfstop) ? BPL_LAST : BPL_FETCH;
          end
        end
        BPL_FETCH: begin
          bpl_active = 1'b1;
          if ((grp_k == 3'd0) && (hctr >= bus.ddfstop)) begin
            bpl_state_d = BPL_LAST;
          end
        end
        BPL_LAST: begin
          bpl_active = 1'b1;
          if (grp_k == 3'd7) begin
            bpl_state_d = BPL_IDLE;
          end
        end
        default: bpl_state_d = BPL_IDLE;
      endcase
    end
  end

  assign bpl_hit = bpl_active && (k_plane != 3'd0) && (k_plane <= bus.bpl_num);

  // Fixed-priority slot winner; blitter/CPU share leftover slots with a
  // starvation counter that only moves on slots they actually contest.
  always_comb begin
    gnt_d    = 8'd0;
    plane_d  = 3'd0;
    spr_d    = 3'd0;
    aud_d    = 2'd0;
    starve_d = starve_q;
    if (ref_hit) begin
      gnt_d[0] = 1'b1;
    end else if (dsk_hit) begin
      gnt_d[1] = 1'b1;
    end else if (aud_hit) begin
      gnt_d[2] = 1'b1;
      aud_d    = aud_idx;
    end else if (bpl_hit) begin
      gnt_d[3] = 1'b1;
      plane_d  = k_plane;
    end else if (spr_hit) begin
      gnt_d[4] = 1'b1;
      spr_d    = spr_idx;
    end else if (cop_hit) begin
      gnt_d[5] = 1'b1;
    end else if (bus.blt_req && bus.cpu_req) begin
      if (!bus.blt_nasty && (starve_q == STARVE_LIM)) begin
        gnt_d[7] = 1'b1;
        starve_d = 3'd0;
      end else begin
        gnt_d[6] = 1'b1;
        if (!bus.blt_nasty) begin
          starve_d = starve_q + 3'd1;
        end
      end
    end else if (bus.blt_req) begin
      gnt_d[6] = 1'b1;
    end else if (bus.cpu_req) begin
      gnt_d[7] = 1'b1;
      starve_d = 3'd0;
    end
    if (!bus.cpu_req) begin
      starve_d = 3'd0;
    end
  end

  // Bitplane window state advances once per slot
  always_ff @(posedge PAD_C28M or negedge PAD_NRST) begin
    if (!PAD_NRST) begin
      bpl_state_q <= BPL_IDLE;
    end else if (bus.slot_stb) begin
      bpl_state_q <= bpl_state_d;
    end
  end

  // Slot decision register: winner and indices held for the whole slot
  always_ff @(posedge PAD_C28M or negedge PAD_NRST) begin
    if (!PAD_NRST) begin
      gnt_q    <= 8'd0;
      plane_q  <= 3'd0;
      spr_q    <= 3'd0;
      aud_q    <= 2'd0;
      starve_q <= 3'd0;
      ndbr_q   <= 1'b1;
    end else if (bus.slot_stb) begin
      gnt_q    <= gnt_d;
      plane_q  <= plane_d;
      spr_q    <= spr_d;
      aud_q    <= aud_d;
      starve_q <= starve_d;
      ndbr_q   <= ~|gnt_d[6:0];
    end
  end

  // CPU acknowledge: a single tick, on the tick the CPU grant loads
  always_ff @(posedge PAD_C28M or negedge PAD_NRST) begin
    if (!PAD_NRST) begin
      cpu_ack_q <= 1'b0;
    end else begin
      cpu_ack_q <= bus.slot_stb && gnt_d[7];
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.bpl_plane = plane_q;
  assign bus.spr_num   = spr_q;
  assign bus.aud_ch    = aud_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.PAD_NDBR  = ndbr_q;

`ifdef ARB_STATS_EN
  logic [15:0] cnt_all [8];

  // vsync_stb is sampled with slot_stb, like every other input
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_stat
      logic [15:0] cnt_q;
      // Saturating granted-slot count for owner gi, restarted each frame
      always_ff @(posedge PAD_C28M or negedge PAD_NRST) begin
        if (!PAD_NRST) begin
          cnt_q <= 16'd0;
        end else if (bus.slot_stb) begin
          if (bus.vsync_stb) begin
            cnt_q <= {15'd0, gnt_d[gi]};
          end else if (gnt_d[gi] && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
      end
      assign cnt_all[gi] = cnt_q;
    end
  endgenerate

  assign bus.stat_cnt = cnt_all[bus.stat_sel];
`else
  logic unused_stats;
  assign unused_stats = ^{bus.vsync_stb, bus.stat_sel};
  assign bus.stat_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dma_slot_arbiter.sv
// Directed bench for dma_slot_arbiter: each slot pushes its expected grant
// into a queue; a monitor compares one tick after every slot strobe.
module tb_dma_slot_arbiter;

  typedef struct {
    logic [7:0] hctr;
    logic [7:0] gnt;
    logic [2:0] plane;
    logic [2:0] spr;
    logic [1:0] aud;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_slot_arbiter_if bus();

  dma_slot_arbiter dut (
    .PAD_C28M (clk),
    .PAD_NRST (rst_n),
    .bus      (bus)
  );

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  logic stb_d1 = 1'b0;
  logic stb_d2 = 1'b0;
  logic bad;
  logic [7:0] last_gnt = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end else begin
      $display("check %s: %0h ok", name, act);
    end
  endtask

  // One slot: strobe for one tick with HCTR, queue the expectation, 8 ticks total
  task automatic do_slot(input logic [7:0] h, input logic [7:0] g,
                         input logic [2:0] pl, input logic [2:0] sn, input logic [1:0] ac);
    exp_t e;
    @(posedge clk); #1;
    bus.slot_stb = 1'b1;
    bus.HCTR     = h;
    e.hctr = h; e.gnt = g; e.plane = pl; e.spr = sn; e.aud = ac;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.slot_stb = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  function automatic logic [2:0] plane_at(input int win, input int h);
    case (win)
      1: case (h)
           'h39, 'h41: return 3'd4;
           'h3B, 'h43: return 3'd2;
           'h3D, 'h45: return 3'd3;
           'h3F, 'h47: return 3'd1;
           default:    return 3'd0;
         endcase
      2: case (h)
           'h51: return 3'd4;
           'h53: return 3'd2;
           'h55: return 3'd3;
           'h57: return 3'd1;
           default: return 3'd0;
         endcase
      3: case (h)
           'h71: return 3'd4;
           'h72: return 3'd6;
           'h73: return 3'd2;
           'h75: return 3'd3;
           'h76: return 3'd5;
           'h77: return 3'd1;
           default: return 3'd0;
         endcase
      default: return 3'd0;
    endcase
  endfunction

  task automatic run_bpl(input int win, input int lo, input int hi);
    logic [2:0] p;
    for (int h = lo; h <= hi; h++) begin
      p = plane_at(win, h);
      do_slot(8'(h), (p != 3'd0) ? 8'h08 : 8'h00, p, 3'd0, 2'd0);
    end
  endtask

  always @(posedge clk) begin
    stb_d1 <= bus.slot_stb;
    stb_d2 <= stb_d1;
  end

  // Monitor: grant is due the tick after each strobe, and must still be
  // held (with cpu_ack gone) one tick later.
  always @(negedge clk) begin
    if (stb_d1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL slot_unexpected: hctr %02h had no queued expectation", bus.HCTR);
      end else begin
        cur = exp_q.pop_front();
        bad = (bus.gnt !== cur.gnt) || (bus.cpu_ack !== cur.gnt[7]) ||
              (bus.PAD_NDBR !== ~|cur.gnt[6:0]) ||
              (cur.gnt[3] && (bus.bpl_plane !== cur.plane)) ||
              (cur.gnt[4] && (bus.spr_num !== cur.spr)) ||
              (cur.gnt[2] && (bus.aud_ch !== cur.aud));
        if (bad) begin
          errors++;
          $display("FAIL slot_%02h: got gnt=%02h plane=%0d spr=%0d aud=%0d ack=%0b ndbr=%0b, expected gnt=%02h plane=%0d spr=%0d aud=%0d ack=%0b ndbr=%0b",
                   cur.hctr, bus.gnt, bus.bpl_plane, bus.spr_num, bus.aud_ch, bus.cpu_ack, bus.PAD_NDBR,
                   cur.gnt, cur.plane, cur.spr, cur.aud, cur.gnt[7], ~|cur.gnt[6:0]);
        end else begin
          $display("slot %02h: gnt=%02h plane=%0d spr=%0d aud=%0d ack=%0b ndbr=%0b ok",
                   cur.hctr, bus.gnt, bus.bpl_plane, bus.spr_num, bus.aud_ch, bus.cpu_ack, bus.PAD_NDBR);
        end
        last_gnt = cur.gnt;
      end
    end
    if (stb_d2) begin
      checks++;
      if ((bus.cpu_ack !== 1'b0) || (bus.gnt !== last_gnt)) begin
        errors++;
        $display("FAIL hold: got gnt=%02h ack=%0b one tick later, expected gnt=%02h ack=0",
                 bus.gnt, bus.cpu_ack, last_gnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.slot_stb = 1'b0; bus.HCTR = 8'd0; bus.dsk_req = 1'b0; bus.aud_req = 4'd0;
    bus.spr_req = 8'd0; bus.bpl_en = 1'b0; bus.bpl_num = 3'd0; bus.ddfstrt = 8'd0;
    bus.ddfstop = 8'd0; bus.cop_req = 1'b0; bus.blt_req = 1'b0; bus.blt_nasty = 1'b0;
    bus.cpu_req = 1'b0; bus.vsync_stb = 1'b0; bus.stat_sel = 3'd0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_plane", 32'(bus.bpl_plane), 32'h0);
    chk("rst_spr", 32'(bus.spr_num), 32'h0);
    chk("rst_aud", 32'(bus.aud_ch), 32'h0);
    chk("rst_ack", 32'(bus.cpu_ack), 32'h0);
    chk("rst_ndbr", 32'(bus.PAD_NDBR), 32'h1);
    chk("rst_stat", 32'(bus.stat_cnt), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Asynchronous reset in the middle of a granted slot
    do_slot(8'h03, 8'h01, 3'd0, 3'd0, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("async_rst_ndbr", 32'(bus.PAD_NDBR), 32'h1);
    @(negedge clk) rst_n = 1'b1;
    do_slot(8'h05, 8'h01, 3'd0, 3'd0, 2'd0);

    // Test 1: idle line, refresh only; vsync at slot 0 restarts the stats
    for (int h = 0; h <= 'hE2; h++) begin
      bus.vsync_stb = (h == 0);
      do_slot(8'(h), (h == 3 || h == 5 || h == 7 || h == 9) ? 8'h01 : 8'h00, 3'd0, 3'd0, 2'd0);
    end
    bus.vsync_stb = 1'b0;

    // Test 6: stats readback
    bus.stat_sel = 3'd0; #1;
`ifdef ARB_STATS_EN
    chk("stat_ref_line", 32'(bus.stat_cnt), 32'd4);
`else
    chk("stat_ref_line", 32'(bus.stat_cnt), 32'd0);
`endif
    bus.stat_sel = 3'd6; #1;
    chk("stat_blt_line", 32'(bus.stat_cnt), 32'd0);
    bus.stat_sel = 3'd0;
    bus.vsync_stb = 1'b1;
    do_slot(8'h10, 8'h00, 3'd0, 3'd0, 2'd0);
    bus.vsync_stb = 1'b0; #1;
    chk("stat_vsync_clear", 32'(bus.stat_cnt), 32'd0);
    bus.vsync_stb = 1'b1;
    do_slot(8'h03, 8'h01, 3'd0, 3'd0, 2'd0);
    bus.vsync_stb = 1'b0; #1;
`ifdef ARB_STATS_EN
    chk("stat_vsync_same_slot", 32'(bus.stat_cnt), 32'd1);
`else
    chk("stat_vsync_same_slot", 32'(bus.stat_cnt), 32'd0);
`endif

    // Test 2: disk, audio channel 2, sprite 0
    bus.dsk_req = 1'b1; bus.aud_req = 4'b0100; bus.spr_req = 8'h01;
    for (int h = 'h0A; h <= 'h1E; h++) begin
      case (h)
        'h0B, 'h0D, 'h0F: do_slot(8'(h), 8'h02, 3'd0, 3'd0, 2'd0);
        'h15:             do_slot(8'(h), 8'h04, 3'd0, 3'd0, 2'd2);
        'h19, 'h1B:       do_slot(8'(h), 8'h10, 3'd0, 3'd0, 2'd0);
        default:          do_slot(8'(h), 8'h00, 3'd0, 3'd0, 2'd0);
      endcase
    end
    bus.dsk_req = 1'b0; bus.aud_req = 4'd0; bus.spr_req = 8'd0;

    // Test 3: bitplane windows
    bus.bpl_en = 1'b1; bus.bpl_num = 3'd4; bus.ddfstrt = 8'h38; bus.ddfstop = 8'h40;
    run_bpl(1, 'h30, 'h4F);
    bus.ddfstrt = 8'h50; bus.ddfstop = 8'h50;
    run_bpl(2, 'h50, 'h5F);
    bus.bpl_num = 3'd6; bus.ddfstrt = 8'h70; bus.ddfstop = 8'h60;
    run_bpl(3, 'h70, 'h7F);
    bus.bpl_num = 3'd0; bus.ddfstrt = 8'h80; bus.ddfstop = 8'h80;
    run_bpl(0, 'h80, 'h87);
    bus.bpl_en = 1'b0;

    // Test 4: blitter vs CPU
    bus.blt_req = 1'b1; bus.cpu_req = 1'b1; bus.blt_nasty = 1'b0;
    for (int h = 'h60; h <= 'h6F; h++)
      do_slot(8'(h), ((h & 3) == 3) ? 8'h80 : 8'h40, 3'd0, 3'd0, 2'd0);
    for (int h = 'h02; h <= 'h0A; h++) begin
      case (h)
        3, 5, 7, 9: do_slot(8'(h), 8'h01, 3'd0, 3'd0, 2'd0);
        8:          do_slot(8'(h), 8'h80, 3'd0, 3'd0, 2'd0);
        default:    do_slot(8'(h), 8'h40, 3'd0, 3'd0, 2'd0);
      endcase
    end
    bus.blt_nasty = 1'b1;
    for (int h = 'h60; h <= 'h67; h++)
      do_slot(8'(h), 8'h40, 3'd0, 3'd0, 2'd0);
    bus.blt_nasty = 1'b0; bus.blt_req = 1'b0;
    do_slot(8'h60, 8'h80, 3'd0, 3'd0, 2'd0);
    do_slot(8'h61, 8'h80, 3'd0, 3'd0, 2'd0);
    bus.cpu_req = 1'b0;

    // Test 5: copper only on even slots
    bus.cop_req = 1'b1;
    do_slot(8'h21, 8'h00, 3'd0, 3'd0, 2'd0);
    do_slot(8'h22, 8'h20, 3'd0, 3'd0, 2'd0);
    do_slot(8'h23, 8'h00, 3'd0, 3'd0, 2'd0);
    bus.cop_req = 1'b0;

    repeat (4) @(posedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
